// File: rtl/lsu_bus_port.sv
// MEM-stage load/store responder: runs one EX/MEM request on a req/ready bus and stalls the pipe until done.
// Optional bus timeout abort is enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_port #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] load_data,
  output logic        stall_mem,
  output logic        mem_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  f3_q;
  logic        we_q;

  logic        access, is_store, legal;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic        timeout;

  assign access   = MemWriteM | MemReadM;
  assign is_store = MemWriteM;

  always_comb begin
    legal = 1'b0;
    case (funct3M)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~ALUResultM[0];
      3'b010:  legal = (ALUResultM[1:0] == 2'b00);
      3'b100:  legal = ~is_store;
      3'b101:  legal = ~is_store & ~ALUResultM[0];
      default: legal = 1'b0;
    endcase
  end

  // Replicate store data across lanes so the strobes alone pick the bytes.
  always_comb begin
    wdata_d = WriteDataM;
    wstrb_d = 4'b1111;
    case (funct3M[1:0])
      2'b00: begin
        wdata_d = {4{WriteDataM[7:0]}};
        wstrb_d = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        wdata_d = {2{WriteDataM[15:0]}};
        wstrb_d = 4'b0011 << ALUResultM[1:0];
      end
      default: begin
        wdata_d = WriteDataM;
        wstrb_d = 4'b1111;
      end
    endcase
    if (!is_store) wstrb_d = 4'b0000;
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign timeout   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign bus_error = err_q;
`else
  assign timeout   = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (access && legal) begin
            addr_q  <= ALUResultM;
            we_q    <= is_store;
            f3_q    <= funct3M;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            state_q <= REQ;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        REQ: begin
          // Ready beats the timeout when both land on the same edge.
          if (bus_ready) begin
            rdata_q <= we_q ? 32'h0 : bus_rdata;
            state_q <= DONE;
          end else if (timeout) begin
            rdata_q <= '0;
            state_q <= DONE;
`ifdef LSU_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
          end else begin
`ifdef LSU_TIMEOUT_EN
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
`ifdef LSU_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;

  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_sel = rdata_q[7:0];
      2'b01:   byte_sel = rdata_q[15:8];
      2'b10:   byte_sel = rdata_q[23:16];
      default: byte_sel = rdata_q[31:24];
    endcase
    half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (f3_q)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext = {24'h0, byte_sel};
      3'b101:  ext = {16'h0, half_sel};
      default: ext = rdata_q;
    endcase
  end

  assign load_data = (state_q == DONE) ? ext : 32'h0;
  assign bus_req   = (state_q == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_wdata = wdata_q;
  assign bus_wstrb = wstrb_q;

  // Gated by reset_n so an asserted reset forces these low even with a request pending.
  assign stall_mem = reset_n & ((state_q == REQ) | ((state_q == IDLE) & access & legal));
  assign mem_fault = reset_n & (state_q == IDLE) & access & ~legal;

endmodule

// File: tb/tb_lsu_bus_port.sv
// Directed bench for lsu_bus_port: loads, stores, faults, reset abort and timeout/no-timeout behaviour.
module tb_lsu_bus_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MemWriteM, MemReadM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] load_data;
  logic        stall_mem, mem_fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_error;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_bus_port #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .load_data(load_data), .stall_mem(stall_mem), .mem_fault(mem_fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_error(bus_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; leaves the DUT idle one cycle after DONE.
  task automatic run_access(input logic w, input logic r, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input int waits,
                            input logic [31:0] rd, input logic [31:0] exp_ld,
                            input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
    int stalls;
    stalls = 0;
    MemWriteM = w; MemReadM = r; funct3M = f3; ALUResultM = a; WriteDataM = wd;
    bus_ready = 1'b0;
    #1;
    check("idle_stall", stall_mem, 1);
    check("idle_req", bus_req, 0);
    check("idle_fault", mem_fault, 0);
    if (stall_mem) stalls++;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      check("req_req", bus_req, 1);
      check("req_addr", bus_addr, exp_addr);
      check("req_we", bus_we, w);
      check("req_strb", bus_wstrb, exp_strb);
      if (w) check("req_wdata", bus_wdata, exp_wdata);
      if (stall_mem) stalls++;
      bus_ready = (i == waits);
      bus_rdata = (i == waits) ? rd : 32'h0BAD_F00D;
    end
    @(negedge clk);
    check("done_req", bus_req, 0);
    check("done_stall", stall_mem, 0);
    check("done_err", bus_error, 0);
    if (r && !w) check("done_load", load_data, exp_ld);
    check("stall_cycles", stalls, waits + 2);
    bus_ready = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b0;
    @(negedge clk);
    check("after_req", bus_req, 0);
    check("after_load", load_data, 0);
  endtask

  task automatic fault_access(input logic w, input logic r, input logic [2:0] f3,
                              input logic [31:0] a);
    MemWriteM = w; MemReadM = r; funct3M = f3; ALUResultM = a; WriteDataM = 32'h1234_5678;
    #1;
    check("flt_fault", mem_fault, 1);
    check("flt_stall", stall_mem, 0);
    check("flt_load", load_data, 0);
    check("flt_req", bus_req, 0);
    @(negedge clk);
    check("flt_req_next", bus_req, 0);
    MemWriteM = 1'b0; MemReadM = 1'b0;
    #1;
    check("flt_clear", mem_fault, 0);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    MemWriteM = 0; MemReadM = 0; funct3M = 0; ALUResultM = 0; WriteDataM = 0;
    bus_ready = 0; bus_rdata = 0;
    @(negedge clk); @(negedge clk);
    check("rst_req", bus_req, 0);
    check("rst_stall", stall_mem, 0);
    check("rst_load", load_data, 0);
    check("rst_strb", bus_wstrb, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_err", bus_error, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_access(0, 1, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 4'b0000, 0);
    run_access(0, 1, 3'b000, 32'h103, 0, 0, 32'h80112233, 32'hFFFFFF80, 32'h100, 4'b0000, 0);
    run_access(0, 1, 3'b100, 32'h103, 0, 1, 32'h80112233, 32'h00000080, 32'h100, 4'b0000, 0);
    run_access(0, 1, 3'b001, 32'h102, 0, 0, 32'h80112233, 32'hFFFF8011, 32'h100, 4'b0000, 0);
    run_access(0, 1, 3'b101, 32'h102, 0, 0, 32'h80112233, 32'h00008011, 32'h100, 4'b0000, 0);
    run_access(0, 1, 3'b000, 32'h101, 0, 0, 32'h80112233, 32'h00000022, 32'h100, 4'b0000, 0);
    run_access(1, 0, 3'b000, 32'h201, 32'h000000A5, 3, 0, 0, 32'h200, 4'b0010, 32'hA5A5A5A5);
    run_access(1, 0, 3'b001, 32'h202, 32'h1234BEEF, 0, 0, 0, 32'h200, 4'b1100, 32'hBEEFBEEF);
    run_access(1, 0, 3'b010, 32'h300, 32'h12345678, 1, 0, 0, 32'h300, 4'b1111, 32'h12345678);
    // Both strobes high: treated as a store.
    run_access(1, 1, 3'b010, 32'h010, 32'hCAFEF00D, 0, 0, 0, 32'h010, 4'b1111, 32'hCAFEF00D);

    fault_access(0, 1, 3'b010, 32'h102);
    fault_access(1, 0, 3'b001, 32'h003);
    fault_access(0, 1, 3'b011, 32'h100);
    fault_access(1, 0, 3'b100, 32'h100);
    fault_access(0, 1, 3'b101, 32'h101);

    // Stray ready while idle must not start anything.
    bus_ready = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("stray_req", bus_req, 0);
    check("stray_stall", stall_mem, 0);
    check("stray_load", load_data, 0);
    bus_ready = 1'b0;
    @(negedge clk);

    // Reset during REQ abandons the transaction.
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h500;
    @(negedge clk);
    check("rstm_req_before", bus_req, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rstm_req", bus_req, 0);
    check("rstm_stall", stall_mem, 0);
    MemReadM = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rstm_idle_req", bus_req, 0);
    check("rstm_idle_stall", stall_mem, 0);
    run_access(0, 1, 3'b010, 32'h504, 0, 0, 32'h0A0B0C0D, 32'h0A0B0C0D, 32'h504, 4'b0000, 0);

    // Bus never ready.
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h400; bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_req", bus_req, 1);
      check("to_stall", stall_mem, 1);
    end
    @(negedge clk);
`ifdef LSU_TIMEOUT_EN
    check("to_req_drop", bus_req, 0);
    check("to_err", bus_error, 1);
    check("to_load", load_data, 0);
    check("to_stall_done", stall_mem, 0);
    MemReadM = 1'b0;
    @(negedge clk);
    check("to_err_clear", bus_error, 0);
    check("to_idle_req", bus_req, 0);
`else
    check("nto_req_hold", bus_req, 1);
    check("nto_stall", stall_mem, 1);
    check("nto_err", bus_error, 0);
    bus_ready = 1'b1; bus_rdata = 32'h55AA55AA;
    @(negedge clk);
    bus_ready = 1'b0;
    check("nto_load", load_data, 32'h55AA55AA);
    check("nto_stall_done", stall_mem, 0);
    MemReadM = 1'b0;
    @(negedge clk);
    check("nto_idle_req", bus_req, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
